// File: rtl/box_move_draw_if.sv
// Pixel-side bundle of the moving-box stage: frame/scan inputs from the video timing
// and collision logic, and the drawing request, colour and position back to the mux.
interface box_move_draw_if;
    logic        startOfFrame;
    logic        enable;
    logic        collision;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        BoxDrawingRequest;
    logic [7:0]  BoxRGB;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;

    modport master (
        output startOfFrame, enable, collision, pixelX, pixelY,
        input  BoxDrawingRequest, BoxRGB, topLeftX, topLeftY
    );

    modport slave (
        input  startOfFrame, enable, collision, pixelX, pixelY,
        output BoxDrawingRequest, BoxRGB, topLeftX, topLeftY
    );
endinterface

// File: rtl/box_move_draw.sv
// Square box that moves one velocity step per frame, bounces off the screen edges,
// and reverses and flashes for a few frames after a collision.
module box_move_draw #(
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          BOX_SIZE     = 32,
    parameter int          INIT_X       = 100,
    parameter int          INIT_Y       = 100,
    parameter int          INIT_VX      = 2,
    parameter int          INIT_VY      = 1,
    parameter logic [7:0]  BOX_COLOR    = 8'hE0,
    parameter logic [7:0]  FLASH_COLOR  = 8'hFF,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic             clk,
    input  logic             resetN,
    box_move_draw_if.slave   bus
);

    typedef enum logic {MOVE, FLASH} state_t;

    typedef struct packed {
        logic signed [11:0] pos;
        logic signed [3:0]  vel;
    } axis_t;

    localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - BOX_SIZE);
    localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - BOX_SIZE);

    state_t             r_state;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic signed [3:0]  r_vx;
    logic signed [3:0]  r_vy;
    logic [7:0]         r_flashCnt;
    logic               r_pending;
    logic               r_drawReq;
    logic [7:0]         r_rgb;

    logic               w_frame;
    logic               w_hit;
    logic signed [3:0]  w_vxEff;
    logic signed [3:0]  w_vyEff;
    axis_t              w_moveX;
    axis_t              w_moveY;
    logic [12:0]        w_px;
    logic [12:0]        w_py;
    logic [12:0]        w_x;
    logic [12:0]        w_y;
    logic               w_inside;

    // Landing exactly on 0 or the max position is not a bounce; only overshoot clamps.
    function automatic axis_t moveAxis(input logic signed [11:0] pos,
                                       input logic signed [3:0]  vel,
                                       input logic signed [11:0] maxPos);
        logic signed [11:0] next;
        logic signed [3:0]  mag;
        axis_t              res;
        next    = pos + {{8{vel[3]}}, vel};
        mag     = vel[3] ? -vel : vel;
        res.pos = next;
        res.vel = vel;
        if (next < 12'sd0) begin
            res.pos = 12'sd0;
            res.vel = mag;
        end else if (next > maxPos) begin
            res.pos = maxPos;
            res.vel = -mag;
        end
        return res;
    endfunction

    // A collision in MOVE (latched or arriving now) flips velocity before the step.
    always_comb begin
        w_frame  = bus.startOfFrame & bus.enable;
        w_hit    = (r_state == MOVE) && (r_pending || bus.collision);
        w_vxEff  = w_hit ? -r_vx : r_vx;
        w_vyEff  = w_hit ? -r_vy : r_vy;
        w_moveX  = moveAxis(r_x, w_vxEff, MAX_X);
        w_moveY  = moveAxis(r_y, w_vyEff, MAX_Y);
        w_px     = {2'b00, bus.pixelX};
        w_py     = {2'b00, bus.pixelY};
        w_x      = {1'b0, r_x};
        w_y      = {1'b0, r_y};
        w_inside = (w_px >= w_x) && (w_px < w_x + 13'(BOX_SIZE)) &&
                   (w_py >= w_y) && (w_py < w_y + 13'(BOX_SIZE));
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_state    <= MOVE;
            r_x        <= 12'(INIT_X);
            r_y        <= 12'(INIT_Y);
            r_vx       <= 4'(INIT_VX);
            r_vy       <= 4'(INIT_VY);
            r_flashCnt <= 8'd0;
            r_pending  <= 1'b0;
            r_drawReq  <= 1'b0;
            r_rgb      <= 8'h00;
        end else begin
            if (w_frame) begin
                case (r_state)
                    MOVE: begin
                        if (w_hit) begin
                            r_state    <= FLASH;
                            r_flashCnt <= 8'(FLASH_FRAMES - 1);
                            r_pending  <= 1'b0;
                        end
                    end
                    FLASH: begin
                        if (r_flashCnt == 8'd0) begin
                            r_state <= MOVE;
                        end else begin
                            r_flashCnt <= r_flashCnt - 8'd1;
                        end
                    end
                    default: r_state <= MOVE;
                endcase
                r_x  <= w_moveX.pos;
                r_vx <= w_moveX.vel;
                r_y  <= w_moveY.pos;
                r_vy <= w_moveY.vel;
            end else if ((r_state == MOVE) && bus.collision) begin
                r_pending <= 1'b1;
            end

            // Draw uses the pre-update position and state of this same cycle.
            r_drawReq <= w_inside;
            if (!w_inside) begin
                r_rgb <= 8'h00;
            end else if (r_state == FLASH) begin
                r_rgb <= FLASH_COLOR;
            end else begin
                r_rgb <= BOX_COLOR;
            end
        end
    end

    assign bus.BoxDrawingRequest = r_drawReq;
    assign bus.BoxRGB            = r_rgb;
    assign bus.topLeftX          = r_x[10:0];
    assign bus.topLeftY          = r_y[10:0];

endmodule

// File: tb/tb_box_move_draw.sv
// Bench for box_move_draw: two instances (default start and near-right-edge start)
// driven by directed and random frame/collision/scan stimulus against an integer model.
module tb_box_move_draw;

    localparam int FF    = 2;
    localparam int MAX_X = 640 - 32;
    localparam int MAX_Y = 480 - 32;

    typedef struct {
        int x;
        int y;
        int vx;
        int vy;
        int cnt;
        bit flash;
        bit pend;
    } mstate_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        en = 1'b1;
    logic        col = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    bit          chkOn = 1'b0;
    int          checks = 0;
    int          failures = 0;

    mstate_t     mA;
    mstate_t     mB;
    int          eReqA, eRgbA, eReqB, eRgbB;

    box_move_draw_if busA ();
    box_move_draw_if busB ();

    assign busA.startOfFrame = sof;
    assign busA.enable       = en;
    assign busA.collision    = col;
    assign busA.pixelX       = px;
    assign busA.pixelY       = py;
    assign busB.startOfFrame = sof;
    assign busB.enable       = en;
    assign busB.collision    = col;
    assign busB.pixelX       = px;
    assign busB.pixelY       = py;

    box_move_draw #(.FLASH_FRAMES(FF)) dutA (
        .clk    (clk),
        .resetN (resetN),
        .bus    (busA)
    );

    box_move_draw #(.INIT_X(606), .INIT_VX(3), .FLASH_FRAMES(FF)) dutB (
        .clk    (clk),
        .resetN (resetN),
        .bus    (busB)
    );

    always #5 clk = ~clk;

    function automatic mstate_t initState(int x, int vx);
        mstate_t s;
        s.x = x; s.y = 100; s.vx = vx; s.vy = 1;
        s.cnt = 0; s.flash = 0; s.pend = 0;
        return s;
    endfunction

    function automatic void moveAxis(input int p, input int v, input int maxP,
                                     output int np, output int nv);
        int mag;
        mag = (v < 0) ? -v : v;
        np = p + v;
        nv = v;
        if (np < 0) begin
            np = 0; nv = mag;
        end else if (np > maxP) begin
            np = maxP; nv = -mag;
        end
    endfunction

    function automatic mstate_t stepModel(mstate_t s, bit frame, bit c);
        mstate_t n;
        n = s;
        if (frame) begin
            if (!s.flash && (s.pend || c)) begin
                n.vx = -s.vx; n.vy = -s.vy;
                n.cnt = FF - 1; n.pend = 0; n.flash = 1;
            end else if (s.flash) begin
                if (s.cnt == 0) n.flash = 0;
                else n.cnt = s.cnt - 1;
            end
            moveAxis(n.x, n.vx, MAX_X, n.x, n.vx);
            moveAxis(n.y, n.vy, MAX_Y, n.y, n.vy);
        end else if (!s.flash && c) begin
            n.pend = 1;
        end
        return n;
    endfunction

    function automatic int insideBox(mstate_t s, int x, int y);
        return (x >= s.x && x < s.x + 32 && y >= s.y && y < s.y + 32) ? 1 : 0;
    endfunction

    function automatic int colourOf(mstate_t s, int x, int y);
        if (insideBox(s, x, y) == 0) return 0;
        return s.flash ? 32'hFF : 32'hE0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input int n);
        int ix, iy;
        for (int i = 0; i < n; i++) begin
            sof = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 7) != 0);
            col = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 0) begin
                ix = $urandom_range(0, 660);
                iy = $urandom_range(0, 500);
            end else begin
                ix = mA.x + $urandom_range(0, 40) - 4;
                iy = mA.y + $urandom_range(0, 40) - 4;
                if (ix < 0) ix = 0;
                if (iy < 0) iy = 0;
            end
            px = 11'(ix);
            py = 11'(iy);
            tick();
        end
        sof = 1'b0; col = 1'b0; en = 1'b1;
    endtask

    // Integer reference: expected draw comes from the state before the edge.
    always @(posedge clk or posedge resetN) begin
        if (resetN) begin
            mA    <= initState(100, 2);
            mB    <= initState(606, 3);
            eReqA <= 0; eRgbA <= 0; eReqB <= 0; eRgbB <= 0;
        end else begin
            eReqA <= insideBox(mA, int'(px), int'(py));
            eRgbA <= colourOf(mA, int'(px), int'(py));
            eReqB <= insideBox(mB, int'(px), int'(py));
            eRgbB <= colourOf(mB, int'(px), int'(py));
            mA    <= stepModel(mA, sof && en, col);
            mB    <= stepModel(mB, sof && en, col);
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            checkOutput("A.topLeftX", int'(busA.topLeftX), mA.x);
            checkOutput("A.topLeftY", int'(busA.topLeftY), mA.y);
            checkOutput("A.request", int'(busA.BoxDrawingRequest), eReqA);
            checkOutput("A.rgb", int'(busA.BoxRGB), eRgbA);
            checkOutput("B.topLeftX", int'(busB.topLeftX), mB.x);
            checkOutput("B.topLeftY", int'(busB.topLeftY), mB.y);
            checkOutput("B.request", int'(busB.BoxDrawingRequest), eReqB);
            checkOutput("B.rgb", int'(busB.BoxRGB), eRgbB);
        end
    end

    initial begin
        #1 resetN = 1'b1;
        repeat (3) tick();
        checkOutput("reset topLeftX", int'(busA.topLeftX), 100);
        checkOutput("reset request", int'(busA.BoxDrawingRequest), 0);
        resetN = 1'b0;
        chkOn  = 1'b1;

        px = 11'd100; py = 11'd100; tick();
        checkOutput("draw corner req", int'(busA.BoxDrawingRequest), 1);
        checkOutput("draw corner rgb", int'(busA.BoxRGB), 32'hE0);
        px = 11'd132; tick();
        checkOutput("draw right req", int'(busA.BoxDrawingRequest), 0);
        checkOutput("draw right rgb", int'(busA.BoxRGB), 0);
        px = 11'd99; tick();
        checkOutput("draw left req", int'(busA.BoxDrawingRequest), 0);

        frame();
        checkOutput("bounce B first", int'(busB.topLeftX), 608);
        frame();
        checkOutput("bounce B second", int'(busB.topLeftX), 605);
        frame();
        checkOutput("motion X", int'(busA.topLeftX), 106);
        checkOutput("motion Y", int'(busA.topLeftY), 103);
        en = 1'b0;
        repeat (3) frame();
        checkOutput("frozen X", int'(busA.topLeftX), 106);
        checkOutput("frozen Y", int'(busA.topLeftY), 103);
        en = 1'b1;

        col = 1'b1; tick(); col = 1'b0; tick();
        frame();
        checkOutput("collide X", int'(busA.topLeftX), 104);
        checkOutput("collide Y", int'(busA.topLeftY), 102);
        px = 11'd110; py = 11'd110; tick();
        checkOutput("flash rgb", int'(busA.BoxRGB), 32'hFF);
        col = 1'b1; tick(); col = 1'b0;
        frame();
        frame();
        checkOutput("after flash X", int'(busA.topLeftX), 100);
        checkOutput("after flash rgb", int'(busA.BoxRGB), 32'hE0);
        frame();
        checkOutput("no pending X", int'(busA.topLeftX), 98);

        sof = 1'b1; col = 1'b1; tick(); sof = 1'b0; col = 1'b0; tick();
        checkOutput("simul X", int'(busA.topLeftX), 100);
        checkOutput("simul rgb", int'(busA.BoxRGB), 32'hFF);

        #1 resetN = 1'b1;
        #1;
        checkOutput("async rst X", int'(busA.topLeftX), 100);
        checkOutput("async rst Y", int'(busA.topLeftY), 100);
        checkOutput("async rst req", int'(busA.BoxDrawingRequest), 0);
        checkOutput("async rst rgb", int'(busA.BoxRGB), 0);
        tick();
        resetN = 1'b0;
        tick();

        applyStimulus(4000);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
